snn_layer_engine: RTL

SNN_LAYER_ENGINE -- requirements
Module: snn_layer_engine

---
 rtl/snn_layer_engine_pkg.sv | 51 +++++
 rtl/snn_layer_engine_lif_update.sv | 41 ++++
 rtl/snn_layer_engine.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/snn_layer_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared definitions for the spiking-neural-network layer
//                engine: FSM state encoding, default parameter constants
//                and width helpers used to size the saturating datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACCUM     = 2'd1,
        ST_LEAK_FIRE = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    localparam int c_DEFAULT_NUM_NEURONS   = 10;
    localparam int c_DEFAULT_DATA_WIDTH    = 8;
    localparam int c_DEFAULT_IMAGE_SIZE    = 784;
    localparam int c_DEFAULT_NUM_TIMESTEPS = 4;
    localparam int c_DEFAULT_POT_WIDTH     = 24;
    localparam int c_DEFAULT_CNT_WIDTH     = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // pixel is zero-extended to DATA_WIDTH+1 signed bits, times a 16-bit
    // signed weight
    function automatic int prod_width(input int data_w);
        return data_w + 17;
    endfunction

    // one guard bit above the wider addend so the pre-clamp sum never wraps
    function automatic int sum_width(input int pot_w, input int data_w);
        return max_int(pot_w, prod_width(data_w)) + 1;
    endfunction

    // signed compare width that holds both the potential and a 16-bit
    // unsigned threshold
    function automatic int cmp_width(input int pot_w);
        return max_int(pot_w, 17);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_layer_engine_lif_update.sv
`default_nettype none
// ============================================================================
//  Module      : lif_update
//  Description : Combinational leak / threshold / reset for one neuron.
//                leaked = v - (v >>> shift); fires when leaked >= threshold.
//  Ports       : v         - current membrane potential (signed)
//                shift     - leak shift amount
//                threshold - unsigned firing threshold
//                fire      - neuron spikes this timestep
//                v_next    - potential after leak (0 when firing)
//  Revision    : 1.0 - initial release
// ============================================================================
module lif_update
    import snn_pkg::*;
#(
    parameter int POT_WIDTH = c_DEFAULT_POT_WIDTH
) (
    input  logic signed [POT_WIDTH-1:0] v,
    input  logic        [3:0]           shift,
    input  logic        [15:0]          threshold,
    output logic                        fire,
    output logic signed [POT_WIDTH-1:0] v_next
);

    localparam int c_CMP_W = cmp_width(POT_WIDTH);

    logic signed [POT_WIDTH-1:0] w_leaked;
    logic signed [c_CMP_W-1:0]   w_leaked_ext;
    logic signed [c_CMP_W-1:0]   w_thr_ext;

    // v - (v >>> s) moves toward zero and cannot overflow; shift 0 yields 0
    always_comb begin
        w_leaked     = v - (v >>> shift);
        w_leaked_ext = c_CMP_W'(w_leaked);
        w_thr_ext    = $signed({{(c_CMP_W-16){1'b0}}, threshold});
        fire         = (w_leaked_ext >= w_thr_ext);
        v_next       = fire ? '0 : w_leaked;
    end

endmodule
`default_nettype wire

// File: rtl/snn_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module      : snn_layer_engine
//  Description : One fully connected leaky-integrate-and-fire layer. Pixels
//                of an image stream in (replayed once per timestep), each
//                neuron accumulates pixel*weight with saturation, then a
//                single leak/fire cycle closes every timestep. Spike counts
//                and a sticky spike vector are reported when the image ends.
//  Ports       : clk, rst_n (async, active low)
//                start                    - begin image (IDLE/DONE only)
//                pixel_valid/pixel_ready  - pixel handshake, ready in ACCUM
//                pixel_data, weights      - pixel and per-neuron weights
//                decays[3:0], thresholds  - per-neuron leak shift, threshold
//                busy, step_done, done    - status
//                spikes_out, spike_counts, winner_idx - results
//  Config      : SNN_ARGMAX_EN - when defined, winner_idx holds the lowest
//                index with the highest spike count; otherwise tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module snn_layer_engine
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS   = c_DEFAULT_NUM_NEURONS,
    parameter int DATA_WIDTH    = c_DEFAULT_DATA_WIDTH,
    parameter int IMAGE_SIZE    = c_DEFAULT_IMAGE_SIZE,
    parameter int NUM_TIMESTEPS = c_DEFAULT_NUM_TIMESTEPS,
    parameter int POT_WIDTH     = c_DEFAULT_POT_WIDTH,
    parameter int CNT_WIDTH     = c_DEFAULT_CNT_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic                                  pixel_valid,
    input  logic [DATA_WIDTH-1:0]                 pixel_data,
    output logic                                  pixel_ready,
    input  logic [NUM_NEURONS-1:0][15:0]          weights,
    input  logic [NUM_NEURONS-1:0][15:0]          decays,
    input  logic [NUM_NEURONS-1:0][15:0]          thresholds,
    output logic                                  busy,
    output logic                                  step_done,
    output logic                                  done,
    output logic [NUM_NEURONS-1:0]                spikes_out,
    output logic [NUM_NEURONS-1:0][CNT_WIDTH-1:0] spike_counts,
    output logic [idx_width(NUM_NEURONS)-1:0]     winner_idx
);

    localparam int c_IDX_W  = idx_width(NUM_NEURONS);
    localparam int c_PROD_W = prod_width(DATA_WIDTH);
    localparam int c_SUM_W  = sum_width(POT_WIDTH, DATA_WIDTH);
    localparam int c_PIX_W  = max_int(1, $clog2(IMAGE_SIZE));
    localparam int c_STEP_W = max_int(1, $clog2(NUM_TIMESTEPS));

    localparam logic [c_PIX_W-1:0]  c_LAST_PIX  = c_PIX_W'(IMAGE_SIZE - 1);
    localparam logic [c_STEP_W-1:0] c_LAST_STEP = c_STEP_W'(NUM_TIMESTEPS - 1);

    // clamp limits, expressed both at sum width and at potential width
    localparam logic signed [c_SUM_W-1:0] c_SUM_MAX =
        {{(c_SUM_W-POT_WIDTH+1){1'b0}}, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [c_SUM_W-1:0] c_SUM_MIN =
        {{(c_SUM_W-POT_WIDTH+1){1'b1}}, {(POT_WIDTH-1){1'b0}}};
    localparam logic signed [POT_WIDTH-1:0] c_POT_MAX = {1'b0, {(POT_WIDTH-1){1'b1}}};
    localparam logic signed [POT_WIDTH-1:0] c_POT_MIN = {1'b1, {(POT_WIDTH-1){1'b0}}};

    state_t                      r_state;
    logic [c_PIX_W-1:0]          r_pix_cnt;
    logic [c_STEP_W-1:0]         r_step_cnt;
    logic [NUM_NEURONS-1:0]      r_spikes;
    logic signed [POT_WIDTH-1:0] r_pot      [NUM_NEURONS];
    logic [CNT_WIDTH-1:0]        r_counts   [NUM_NEURONS];

    logic signed [POT_WIDTH-1:0] w_acc      [NUM_NEURONS];
    logic signed [POT_WIDTH-1:0] w_lif_next [NUM_NEURONS];
    logic [CNT_WIDTH-1:0]        w_cnt_next [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]      w_fire;
    logic [NUM_NEURONS-1:0]      w_decay_unused;

    logic w_start_ok;
    logic w_last_step;

    assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_last_step = (r_step_cnt == c_LAST_STEP);

    assign pixel_ready = (r_state == ST_ACCUM);
    assign busy        = (r_state == ST_ACCUM) || (r_state == ST_LEAK_FIRE);
    assign step_done   = (r_state == ST_LEAK_FIRE);
    assign done        = (r_state == ST_DONE);
    assign spikes_out  = r_spikes;

    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_neuron
            logic signed [c_PROD_W-1:0] w_prod;
            logic signed [c_SUM_W-1:0]  w_sum;

            always_comb begin
                w_prod = $signed({1'b0, pixel_data}) * $signed(weights[gi]);
                w_sum  = c_SUM_W'(r_pot[gi]) + c_SUM_W'(w_prod);
                if (w_sum > c_SUM_MAX) begin
                    w_acc[gi] = c_POT_MAX;
                end else if (w_sum < c_SUM_MIN) begin
                    w_acc[gi] = c_POT_MIN;
                end else begin
                    w_acc[gi] = w_sum[POT_WIDTH-1:0];
                end
            end

            lif_update #(
                .POT_WIDTH (POT_WIDTH)
            ) u_lif (
                .v         (r_pot[gi]),
                .shift     (decays[gi][3:0]),
                .threshold (thresholds[gi]),
                .fire      (w_fire[gi]),
                .v_next    (w_lif_next[gi])
            );

            // counter sticks at all-ones instead of wrapping
            assign w_cnt_next[gi] = (w_fire[gi] && (r_counts[gi] != '1))
                                  ? r_counts[gi] + 1'b1 : r_counts[gi];

            assign spike_counts[gi]   = r_counts[gi];
            assign w_decay_unused[gi] = ^decays[gi][15:4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pix_cnt  <= '0;
            r_step_cnt <= '0;
            r_spikes   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                r_pot[i]    <= '0;
                r_counts[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_ACCUM;
                        r_pix_cnt  <= '0;
                        r_step_cnt <= '0;
                        r_spikes   <= '0;
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            r_pot[i]    <= '0;
                            r_counts[i] <= '0;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (pixel_valid) begin
                        for (int i = 0; i < NUM_NEURONS; i++) begin
                            r_pot[i] <= w_acc[i];
                        end
                        if (r_pix_cnt == c_LAST_PIX) begin
                            r_pix_cnt <= '0;
                            r_state   <= ST_LEAK_FIRE;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                end
                ST_LEAK_FIRE: begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        r_pot[i]    <= w_lif_next[i];
                        r_counts[i] <= w_cnt_next[i];
                    end
                    r_spikes <= r_spikes | w_fire;
                    if (w_last_step) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_step_cnt <= r_step_cnt + 1'b1;
                        r_state    <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SNN_ARGMAX_EN
    logic [c_IDX_W-1:0] w_best_idx;
    logic [c_IDX_W-1:0] r_winner;

    // argmax over the counts being written this cycle, so the final
    // timestep's spikes are included; strict '>' keeps the lowest index on ties
    always_comb begin
        logic [CNT_WIDTH-1:0] v_best;
        v_best     = w_cnt_next[0];
        w_best_idx = '0;
        for (int i = 1; i < NUM_NEURONS; i++) begin
            if (w_cnt_next[i] > v_best) begin
                v_best     = w_cnt_next[i];
                w_best_idx = c_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_winner <= '0;
        end else if (w_start_ok) begin
            r_winner <= '0;
        end else if (r_state == ST_LEAK_FIRE && w_last_step) begin
            r_winner <= w_best_idx;
        end
    end

    assign winner_idx = r_winner;
`else
    assign winner_idx = '0;
`endif

endmodule
`default_nettype wire
